// File: rtl/aw_addr_queue.sv
// aw_addr_queue: AXI4-Lite AW-channel address queue with entry-time decode.
// Ports: AW* master side, ADDR* consumer side, FLUSH, COUNT, ERRCNT.
module aw_addr_queue #(
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 4,
  parameter int NUM_REGS   = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      AWVALID,
  input  logic [ADDR_WIDTH-1:0]     AWADDR,
  input  logic [2:0]                AWPROT,
  output logic                      AWREADY,
  output logic                      ADDRVALID,
  input  logic                      ADDRTAKE,
  output logic [ADDR_WIDTH-1:0]     AWADDROUT,
  output logic [2:0]                AWPROTOUT,
  output logic [1:0]                ADDRERR,
  input  logic                      FLUSH,
  output logic [$clog2(DEPTH):0]    COUNT,
  output logic [7:0]                ERRCNT
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [2:0]            prot;
    logic [1:0]            code;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wp;
  logic [PW-1:0]   rp;
  logic [CW-1:0]   cnt;
  logic [7:0]      errcnt;

  logic            push;
  logic            pop;
  logic            push_ok;
  logic            dec_hit;
  logic            mis_hit;
  logic [1:0]      code;
  logic [31:0]     widx;
  entry_t          head;

  assign AWREADY   = !reset && (cnt != CW'(DEPTH));
  assign ADDRVALID = (cnt != '0);
  assign push      = AWVALID && AWREADY;
  assign pop       = ADDRVALID && ADDRTAKE;
  // a flush discards any concurrent push, so it must not count as an error
  assign push_ok   = push && !FLUSH;

  assign widx    = 32'(AWADDR[ADDR_WIDTH-1:2]);
  assign dec_hit = (widx >= 32'(NUM_REGS));
  assign mis_hit = (AWADDR[1:0] != 2'b00);

  always_comb begin
    code = OKAY;
    unique case (1'b1)
      dec_hit:            code = DECERR;
      !dec_hit & mis_hit: code = SLVERR;
      default:            code = OKAY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wp] <= '{addr: AWADDR, prot: AWPROT, code: code};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (FLUSH) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      if (push && !pop)
        cnt <= cnt + 1'b1;
      else if (pop && !push)
        cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      errcnt <= '0;
    end else if (push_ok && (code != OKAY) && (errcnt != 8'hff)) begin
      errcnt <= errcnt + 8'd1;
    end
  end

  assign head = mem[rp];

  always_comb begin
    AWADDROUT = '0;
    AWPROTOUT = '0;
    ADDRERR   = '0;
    if (ADDRVALID) begin
      AWADDROUT = head.addr;
      AWPROTOUT = head.prot;
      ADDRERR   = head.code;
    end
  end

  assign COUNT  = cnt;
  assign ERRCNT = errcnt;

endmodule

// File: doc/aw_addr_queue.md
# aw_addr_queue

Parametrised AXI4-Lite write-address channel front end, the successor to the single-entry AW stage. It accepts up to DEPTH outstanding write addresses from the master, decodes and range-checks each address on entry, and presents them in order to the write-pairing logic that joins them with W data. Each entry carries its pre-computed B-channel response code, so the B channel never re-decodes the address.

## Interface
Parameters:
- ADDR_WIDTH, 5: byte-address width; must be >= 3.
- DEPTH, 4: queue entries; power of two, >= 2.
- NUM_REGS, 8: number of 32-bit registers implemented. The legal word index range is 0..NUM_REGS-1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- AWVALID  in  1  master address valid.
- AWADDR  in  ADDR_WIDTH  master write byte address.
- AWPROT  in  3  master protection bits, carried through unmodified.
- AWREADY  out  1  queue can accept an address.
- ADDRVALID  out  1  head entry is available to the consumer.
- ADDRTAKE  in  1  consumer pops the head entry; ignored while ADDRVALID=0.
- AWADDROUT  out  ADDR_WIDTH  head entry address.
- AWPROTOUT  out  3  head entry AWPROT.
- ADDRERR  out  2  head entry response code: 00 OKAY, 10 SLVERR, 11 DECERR.
- FLUSH  in  1  synchronous clear of all entries.
- COUNT  out  $clog2(DEPTH)+1  number of occupied entries.
- ERRCNT  out  8  saturating count of accepted addresses whose code is non-OKAY.

## Operation
- The block is a circular buffer with write pointer, read pointer and occupancy count. Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
- Push happens on any cycle where AWVALID && AWREADY. The entry stores AWADDR, AWPROT and a code computed from AWADDR in the same cycle:
  - DECERR if AWADDR[ADDR_WIDTH-1:2] >= NUM_REGS;
  - else SLVERR if AWADDR[1:0] != 0;
  - else OKAY.
  - DECERR has priority over SLVERR.
- Pop happens on any cycle where ADDRVALID && ADDRTAKE; the read pointer advances.
- Simultaneous push and pop: COUNT is unchanged and both pointers advance.
- AWREADY = !reset && (COUNT != DEPTH), driven combinationally from registered state only; it never depends on AWVALID.
- Full queue: AWREADY=0. A pop in that same cycle does not open a slot for a push in that same cycle (no bypass); AWREADY rises the next cycle.
- Empty queue: ADDRVALID=0. A push does not appear on the outputs until the next cycle (no flow-through).
- ADDRVALID = (COUNT != 0).
- AWADDROUT, AWPROTOUT and ADDRERR show the head entry while ADDRVALID=1 and are forced to 0 while ADDRVALID=0.
- ERRCNT increments by 1 on each push whose code is non-OKAY and saturates at 255. It is not cleared by FLUSH.
- FLUSH has priority over push and pop in the same cycle. It zeroes the pointers and COUNT; any concurrent push or pop is discarded.
- Once accepted, a master address is never dropped except by FLUSH or reset.

## Timing
- Reset (asynchronous assert, release on a clock edge) sets:
  - pointers=0, COUNT=0, ERRCNT=0;
  - AWREADY=0 while reset is high, 1 after release;
  - ADDRVALID=0;
  - AWADDROUT, AWPROTOUT, ADDRERR = 0.
- Reset asserted mid-operation empties the queue immediately; in-flight entries are lost.
- Latency: a push at edge N makes ADDRVALID=1 after edge N (one cycle), provided the queue was empty.
- Throughput: one push and one pop per cycle, sustained.
- COUNT and ERRCNT reflect state after the most recent edge.

## Test plan
- Reset then single write: AWADDR=0x08, AWPROT=3'b010 -> ADDRVALID=1 one cycle later with AWADDROUT=0x08, AWPROTOUT=010, ADDRERR=00, COUNT=1. Then ADDRTAKE=1 -> COUNT=0 and outputs back to 0.
- Fill with DEPTH=4 and ADDRTAKE=0: push 0x00, 0x04, 0x08, 0x0C -> AWREADY=0 and COUNT=4. Pop with AWVALID held high -> AWREADY returns to 1 one cycle later, and no push is accepted in the pop cycle.
- Decode checks with NUM_REGS=8, ADDR_WIDTH=5:
  - 0x1C -> code 00;
  - 0x06 -> code 10;
  - push 0x20 is not possible at width 5, so rerun with ADDR_WIDTH=6 and push 0x20 -> code 11;
  - 0x21 -> code 11 (DECERR priority).
  - ERRCNT rises by one per non-OKAY push.
- Wrap and concurrency: a continuous stream of 10 addresses with ADDRTAKE held high -> COUNT stays at 1 after the first cycle, and output order exactly matches input order across pointer wrap.
- FLUSH with COUNT=3 in the same cycle as a push and a pop -> COUNT=0, ADDRVALID=0, ERRCNT unchanged.
- ERRCNT saturation: 260 misaligned pushes -> ERRCNT=255.
